image_stream_gen: RTL and testbench
===================================

// Module: image_stream_gen
// PURPOSE
//  Upstream pixel source for the BMP writer stage. On a start pulse it reads one
//  frame of packed RGB888 pixel pairs from a synchronous frame RAM, raster order,
//  top row first. It applies a per-channel point operation (pass, brighten,
//  darken, invert) and drives hsync plus six 8-bit pixel channels, one pair per cycle.
// PARAMETERS
//  WIDTH       768    pixels per line; must be even
//  HEIGHT      512    lines per frame
//  ADDR_W      18     RAM address width; 2**ADDR_W >= WIDTH*HEIGHT/2
//  START_DELAY 100    idle cycles between accepted start and the first read (>=1)
//  HBLANK      160    hsync-low cycles between lines (0 = back-to-back)
// PORTS
//  HCLK          in   1       clock, rising edge
//  HRESETn       in   1       reset, asynchronous, active-low
//  start         in   1       1-cycle request to stream a frame; ignored while busy
//  mode          in   2       00 pass, 01 add value, 10 subtract value, 11 invert
//  value         in   8       operand for add/subtract
//  mem_rd_en     out  1       RAM read strobe
//  mem_addr      out  ADDR_W  pair address = line*WIDTH/2 + pair
//  mem_rdata     in   48      {R0,G0,B0,R1,G1,B1}; valid 1 cycle after mem_rd_en
//  vsync         out  1       high from first read until last pair leaves
//  hsync         out  1       high exactly when DATA_* hold a valid pair
//  DATA_R0/G0/B0 out  8 each  even pixel (column 2m)
//  DATA_R1/G1/B1 out  8 each  odd pixel (column 2m+1)
//  busy          out  1       high from accepted start until frame_done
//  frame_done    out  1       1-cycle pulse after the last pair
// BEHAVIOUR
//  - Reset: all outputs 0, FSM in IDLE, counters 0. Reset mid-frame aborts the frame
//    at once. No frame_done is issued. The next frame starts clean at address 0.
//  - mode and value are latched on the accepted start and held for the whole frame.
//  - FSM:
//    - IDLE: start moves to VWAIT; busy goes high next cycle.
//    - VWAIT: wait START_DELAY cycles, then go to LINE.
//    - LINE: assert mem_rd_en for WIDTH/2 consecutive cycles, address +1 each cycle.
//      After the last pair of a line:
//      - last line: go to DRAIN
//      - HBLANK=0: go to LINE
//      - otherwise: go to HBL
//    - HBL: HBLANK cycles with no reads, then go to LINE.
//    - DRAIN: wait for the pipeline to empty. Pulse frame_done, drop busy, go to IDLE.
//  - Pipeline latency is 2 cycles: rd_en at t, rdata at t+1, op registered, and
//    hsync/DATA_* at t+2. hsync is rd_en delayed by 2 cycles exactly.
//  - Output spacing: WIDTH/2 hsync cycles per line, separated by exactly HBLANK low
//    cycles. Total hsync-high cycles per frame = WIDTH*HEIGHT/2 (196608 at defaults).
//  - DATA_* hold their last value while hsync is low.
//  - Point op per 8-bit channel c:
//    - add: min(c+value, 255), using a 9-bit sum
//    - subtract: max(c-value, 0)
//    - invert: 255-c
//    - pass: c
//  - frame_done is asserted the cycle after the final hsync-high cycle, while vsync
//    falls. busy falls together with frame_done.
//  - start while busy has no effect, including start in the same cycle as frame_done.
//    start in IDLE with HRESETn low has no effect.
//  - Address and line/pair counters wrap to 0 at end of frame. No out-of-range address
//    is ever driven.
// STRUCTURE
//  - Shared package img_pkg:
//    - mode constants MODE_PASS, MODE_ADD, MODE_SUB, MODE_INV
//    - FSM state encoding
//    - RGB888 width constant (8) and pair width (48)
//  - Sub-module pixel_point_op: combinational, 8-bit in plus mode/value to 8-bit out.
//    Instantiated six times; the outputs are registered in this block.
//  - Top level holds the FSM, the line/pair/delay counters and the 2-stage valid pipe.
// TESTING
//  1. WIDTH=8, HEIGHT=4, HBLANK=3, mode=00, RAM word k = {6{k[7:0]}}
//     -> 16 hsync cycles in 4 bursts of 4 with 3-cycle gaps.
//     -> DATA equals RAM in address order; one frame_done pulse.
//  2. mode=01, value=100, RAM channels 200/10/155 -> outputs 255/110/255 (saturation).
//  3. mode=10, value=50, channels 30/50/51 -> 0/0/1.
//     mode=11 on channel 0x3C -> 0xC3.
//  4. start pulses every 5 cycles during a frame -> only one frame is streamed.
//     Address sequence unbroken; mode change mid-frame has no effect on output.
//  5. HRESETn low after line 2 -> all outputs 0 asynchronously, no frame_done.
//     Next start streams from address 0.
//  6. HBLANK=0, defaults otherwise -> hsync continuously high for 196608 cycles.
//     frame_done fires 1 cycle after the last pair; the writer's Write_Done then asserts.

Source files
------------

// File: rtl/img_pkg.sv
// Shared constants and FSM encoding for the image stream source.
package img_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_ADD  = 2'b01;
  localparam logic [1:0] MODE_SUB  = 2'b10;
  localparam logic [1:0] MODE_INV  = 2'b11;

  localparam int PIX_W  = 8;
  localparam int PAIR_W = 48;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VWAIT,
    S_LINE,
    S_HBL,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/image_stream_gen_point_op.sv
// Per-channel point operation: pass, saturating add/sub, invert.
module pixel_point_op
  import img_pkg::*;
(
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] value,
  input  logic [PIX_W-1:0] pix,
  output logic [PIX_W-1:0] res
);

  logic [PIX_W:0] sum;

  always_comb begin
    sum = {1'b0, pix} + {1'b0, value};
    res = pix;
    unique case (mode)
      MODE_PASS: res = pix;
      MODE_ADD:  res = sum[PIX_W] ? '1 : sum[PIX_W-1:0];
      MODE_SUB:  res = (pix >= value) ? pix - value : '0;
      MODE_INV:  res = ~pix;
      default:   res = pix;
    endcase
  end

endmodule

// File: rtl/image_stream_gen.sv
// Frame reader: raster-order pair reads, point op, hsync/vsync framing.
module image_stream_gen
  import img_pkg::*;
#(
  parameter int WIDTH       = 768,
  parameter int HEIGHT      = 512,
  parameter int ADDR_W      = 18,
  parameter int START_DELAY = 100,
  parameter int HBLANK      = 160
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [7:0]        value,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [47:0]       mem_rdata,
  output logic              vsync,
  output logic              hsync,
  output logic [7:0]        DATA_R0,
  output logic [7:0]        DATA_G0,
  output logic [7:0]        DATA_B0,
  output logic [7:0]        DATA_R1,
  output logic [7:0]        DATA_G1,
  output logic [7:0]        DATA_B1,
  output logic              busy,
  output logic              frame_done
);

  localparam int PCW = $clog2(WIDTH/2 + 1);
  localparam int LCW = $clog2(HEIGHT + 1);

  state_t state, state_n;

  logic [31:0]       dly;
  logic [PCW-1:0]    pair;
  logic [LCW-1:0]    line;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        mode_q;
  logic [7:0]        value_q;
  logic              v1;
  logic              accept;
  logic              pair_last;
  logic              line_last;
  logic              drain_end;
  logic [PIX_W-1:0]  pix_op [6];
  logic [PIX_W-1:0]  pix_q  [6];

  assign accept    = (state == S_IDLE) && start && !frame_done;
  assign pair_last = (pair == PCW'(WIDTH/2 - 1));
  assign line_last = (line == LCW'(HEIGHT - 1));
  assign drain_end = (state == S_DRAIN) && !v1;
  assign mem_rd_en = (state == S_LINE);
  assign mem_addr  = addr;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (accept) state_n = S_VWAIT;
      S_VWAIT: if (dly == 32'(START_DELAY - 1)) state_n = S_LINE;
      S_LINE: begin
        if (pair_last) begin
          if (line_last)        state_n = S_DRAIN;
          else if (HBLANK == 0) state_n = S_LINE;
          else                  state_n = S_HBL;
        end
      end
      S_HBL:   if (dly == 32'(HBLANK) - 32'd1) state_n = S_LINE;
      S_DRAIN: if (!v1) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Counters advance only on reads, so the address never leaves the frame.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dly     <= '0;
      pair    <= '0;
      line    <= '0;
      addr    <= '0;
      mode_q  <= MODE_PASS;
      value_q <= '0;
    end else begin
      if ((state_n == state) &&
          (state == S_VWAIT || state == S_HBL))
        dly <= dly + 32'd1;
      else
        dly <= '0;
      if (accept) begin
        mode_q  <= mode;
        value_q <= value;
      end
      if (mem_rd_en) begin
        pair <= pair_last ? '0 : pair + 1'b1;
        addr <= (pair_last && line_last) ? '0 : addr + 1'b1;
        if (pair_last)
          line <= line_last ? '0 : line + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < 6; i++) begin : g_ch
    pixel_point_op u_op (
      .mode  (mode_q),
      .value (value_q),
      .pix   (mem_rdata[PAIR_W-1-PIX_W*i -: PIX_W]),
      .res   (pix_op[i])
    );
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      v1         <= 1'b0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 6; i++) pix_q[i] <= '0;
    end else begin
      v1         <= mem_rd_en;
      hsync      <= v1;
      frame_done <= drain_end;
      if (v1)
        for (int i = 0; i < 6; i++) pix_q[i] <= pix_op[i];
      if (accept)         busy <= 1'b1;
      else if (drain_end) busy <= 1'b0;
      if (state == S_VWAIT && state_n == S_LINE) vsync <= 1'b1;
      else if (drain_end)                        vsync <= 1'b0;
    end
  end

  assign DATA_R0 = pix_q[0];
  assign DATA_G0 = pix_q[1];
  assign DATA_B0 = pix_q[2];
  assign DATA_R1 = pix_q[3];
  assign DATA_G1 = pix_q[4];
  assign DATA_B1 = pix_q[5];

endmodule

// File: tb/tb_image_stream_gen.sv
// Bench: two small instances (HBLANK=3 and 0) checked each cycle
// against an arithmetic timing/data model of one frame.
module tb_image_stream_gen;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int D  = 3;
  localparam int NP = W * H / 2;

  logic HCLK = 1'b0;
  logic HRESETn;
  logic start0, start1;
  logic [1:0] mode;
  logic [7:0] value;

  logic [47:0] ram [NP];

  logic        rd0, rd1, vs0, vs1, hs0, hs1;
  logic        bz0, bz1, fd0, fd1;
  logic [3:0]  ad0, ad1;
  logic [47:0] rq0, rq1;
  logic [7:0]  r00, g00, b00, r10, g10, b10;
  logic [7:0]  r01, g01, b01, r11, g11, b11;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int t0 [2] = '{-1, -1};
  int m_mode [2];
  int m_val [2];

  int          seen_t0 [2] = '{-1, -1};
  bit          frame_on [2] = '{0, 0};
  logic [47:0] last_data [2] = '{48'h0, 48'h0};
  int          hs_tot [2] = '{0, 0};
  int          fd_tot [2] = '{0, 0};

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  always @(posedge HCLK) begin
    if (rd0) rq0 <= ram[ad0];
    if (rd1) rq1 <= ram[ad1];
  end

  image_stream_gen #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(4),
    .START_DELAY(D), .HBLANK(3)
  ) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start0),
    .mode(mode), .value(value),
    .mem_rd_en(rd0), .mem_addr(ad0), .mem_rdata(rq0),
    .vsync(vs0), .hsync(hs0),
    .DATA_R0(r00), .DATA_G0(g00), .DATA_B0(b00),
    .DATA_R1(r10), .DATA_G1(g10), .DATA_B1(b10),
    .busy(bz0), .frame_done(fd0)
  );

  image_stream_gen #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(4),
    .START_DELAY(D), .HBLANK(0)
  ) u_dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start1),
    .mode(mode), .value(value),
    .mem_rd_en(rd1), .mem_addr(ad1), .mem_rdata(rq1),
    .vsync(vs1), .hsync(hs1),
    .DATA_R0(r01), .DATA_G0(g01), .DATA_B0(b01),
    .DATA_R1(r11), .DATA_G1(g11), .DATA_B1(b11),
    .busy(bz1), .frame_done(fd1)
  );

  task automatic cmp(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h want %0h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] pt(input int md, input int v,
                                    input int c);
    int r;
    case (md)
      1:       r = (c + v > 255) ? 255 : c + v;
      2:       r = (c - v < 0) ? 0 : c - v;
      3:       r = 255 - c;
      default: r = c;
    endcase
    return 8'(r);
  endfunction

  function automatic logic [47:0] pair_op(input int md, input int v,
                                          input logic [47:0] w);
    logic [47:0] o;
    for (int i = 0; i < 6; i++)
      o[47-8*i -: 8] = pt(md, v, int'(w[47-8*i -: 8]));
    return o;
  endfunction

  // Pairs read before cycle offset r from first read, modulo frame size.
  function automatic int reads_before(input int r, input int per);
    int l, p, n;
    if (r <= 0) return 0;
    l = r / per;
    p = r % per;
    n = l * (W/2) + ((p < W/2) ? p : W/2);
    if (l >= H) n = NP;
    return n % NP;
  endfunction

  task automatic chk_dut(input int d, input int hb,
                         input logic hs, input logic vs,
                         input logic bz, input logic fd,
                         input logic rd, input logic [3:0] ad,
                         input logic [47:0] dat);
    int k, per, last, r, r2;
    logic e_hs, e_vs, e_bz, e_fd, e_rd;
    logic [3:0] e_ad;
    string s;
    e_hs = 0; e_vs = 0; e_bz = 0; e_fd = 0; e_rd = 0;
    e_ad = '0; k = 0;
    per  = W/2 + hb;
    last = D + 2 + (H-1)*per + W/2 - 1;
    if (!HRESETn) begin
      frame_on[d]  = 0;
      last_data[d] = '0;
    end else if (t0[d] != seen_t0[d]) begin
      seen_t0[d]  = t0[d];
      frame_on[d] = 1;
      hs_tot[d]   = 0;
      fd_tot[d]   = 0;
    end
    if (HRESETn && frame_on[d]) begin
      k    = cyc - t0[d];
      e_bz = (k >= 0 && k <= last);
      e_vs = (k >= D && k <= last);
      e_fd = (k == last + 1);
      r    = k - D;
      r2   = k - D - 2;
      e_ad = 4'(reads_before(r, per));
      if (r >= 0 && r / per < H && r % per < W/2) e_rd = 1;
      if (r2 >= 0 && r2 / per < H && r2 % per < W/2) begin
        e_hs = 1;
        last_data[d] = pair_op(m_mode[d], m_val[d],
                         ram[(r2/per)*(W/2) + r2 % per]);
      end
    end
    s = $sformatf("dut%0d", d);
    cmp({s, ".hsync"}, hs, e_hs);
    cmp({s, ".vsync"}, vs, e_vs);
    cmp({s, ".busy"}, bz, e_bz);
    cmp({s, ".frame_done"}, fd, e_fd);
    cmp({s, ".mem_rd_en"}, rd, e_rd);
    cmp({s, ".mem_addr"}, ad, e_ad);
    cmp({s, ".data"}, dat, last_data[d]);
    if (hs) hs_tot[d]++;
    if (fd) fd_tot[d]++;
    if (frame_on[d] && k == last + 1) frame_on[d] = 0;
  endtask

  always @(negedge HCLK) begin
    chk_dut(0, 3, hs0, vs0, bz0, fd0, rd0, ad0,
            {r00, g00, b00, r10, g10, b10});
    chk_dut(1, 0, hs1, vs1, bz1, fd1, rd1, ad1,
            {r01, g01, b01, r11, g11, b11});
  end

  task automatic kick(input logic [1:0] md, input logic [7:0] v);
    @(negedge HCLK);
    start0 = 1'b1;
    start1 = 1'b1;
    mode   = md;
    value  = v;
    for (int d = 0; d < 2; d++) begin
      t0[d]     = cyc + 1;
      m_mode[d] = int'(md);
      m_val[d]  = int'(v);
    end
    @(negedge HCLK);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Last hsync of dut0 is cycle 29 and of dut1 is cycle 20.
  task automatic run_frame(input logic [1:0] md, input logic [7:0] v,
                           input logic [47:0] lit, input bit spam);
    kick(md, v);
    for (int i = 1; i < 38; i++) begin
      @(negedge HCLK);
      start0 = spam && ((i % 5 == 0 && i < 21) || i == 30);
      start1 = spam && ((i % 5 == 0 && i < 21) || i == 21);
      if (spam && i == 10) begin
        mode  = 2'b11;
        value = 8'd7;
      end
      if (i == D + 2) begin
        cmp("first_pair0", {r00, g00, b00, r10, g10, b10}, lit);
        cmp("first_pair1", {r01, g01, b01, r11, g11, b11}, lit);
      end
    end
    start0 = 1'b0;
    start1 = 1'b0;
    cmp("hs_count0", 64'(hs_tot[0]), 64'd16);
    cmp("hs_count1", 64'(hs_tot[1]), 64'd16);
    cmp("done_count0", 64'(fd_tot[0]), 64'd1);
    cmp("done_count1", 64'(fd_tot[1]), 64'd1);
  endtask

  initial begin
    HRESETn = 1'b0;
    start0  = 1'b0;
    start1  = 1'b0;
    mode    = 2'b00;
    value   = 8'd0;
    for (int k = 0; k < NP; k++) ram[k] = {6{8'(k)}};
    repeat (2) @(posedge HCLK);
    #2 HRESETn = 1'b1;
    repeat (3) @(negedge HCLK);

    run_frame(2'b00, 8'd0, 48'h0, 1'b0);

    ram[0] = {8'd200, 8'd10, 8'd155, 8'd200, 8'd10, 8'd155};
    run_frame(2'b01, 8'd100,
      {8'd255, 8'd110, 8'd255, 8'd255, 8'd110, 8'd255}, 1'b1);

    ram[0] = {8'd30, 8'd50, 8'd51, 8'd30, 8'd50, 8'd51};
    run_frame(2'b10, 8'd50,
      {8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1}, 1'b0);

    ram[0] = {6{8'h3C}};
    run_frame(2'b11, 8'd0, {6{8'hC3}}, 1'b0);

    ram[0] = 48'h0;
    kick(2'b00, 8'd0);
    repeat (D + 2*7 + 1) @(negedge HCLK);
    @(posedge HCLK);
    #2 HRESETn = 1'b0;
    #1;
    cmp("rst_hsync", hs0, 1'b0);
    cmp("rst_vsync", vs0, 1'b0);
    cmp("rst_busy", bz0, 1'b0);
    cmp("rst_rd_en", rd0, 1'b0);
    cmp("rst_addr", ad0, 4'd0);
    cmp("rst_data", {r00, g00, b00, r10, g10, b10}, 48'h0);
    cmp("rst_busy1", bz1, 1'b0);
    repeat (3) @(negedge HCLK);
    @(posedge HCLK);
    #2 HRESETn = 1'b1;
    repeat (6) @(negedge HCLK);

    run_frame(2'b00, 8'd0, 48'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
